// File: rtl/writeback.sv
// writeback: in-order write-back queue feeding the register-file write port.
// Results from execute/memory are queued (rd==0 results are dropped), then
// drained one per cycle on wr_ack_i. A drain request stops intake and pulses
// drained_o once all pending writes have committed.
// Optional feature macro: WB_FORWARD_EN (pending-write forwarding lookups).
// States:
//   RUN   | normal operation, results accepted when not full
//   DRAIN | intake stopped, queue pops until empty, then back to RUN
module writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [AW-1:0]              res_rd_i,
  input  logic [XLEN-1:0]            res_data_i,
  output logic                       wr_en_o,
  output logic [AW-1:0]              wr_addr_o,
  output logic [XLEN-1:0]            wr_data_o,
  input  logic                       wr_ack_i,
  input  logic                       drain_i,
  output logic                       drained_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [31:0]                retired_o,
  input  logic [AW-1:0]              rs1_i,
  input  logic [AW-1:0]              rs2_i,
  output logic                       fwd_a_hit_o,
  output logic                       fwd_b_hit_o,
  output logic [XLEN-1:0]            fwd_a_data_o,
  output logic [XLEN-1:0]            fwd_b_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     rd_q   [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [31:0]       retired;
  logic              push, pop, empty, full;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready depends only on registered state so wr_ack_i never reaches it.
  assign res_ready_o = (state == RUN) && !full;
  assign push        = res_valid_i && res_ready_o && (res_rd_i != '0) && !reset;
  // No write is issued while reset is asserted.
  assign wr_en_o     = !empty && !reset;
  assign pop         = wr_en_o && wr_ack_i;

  assign wr_addr_o = wr_en_o ? rd_q[head]   : '0;
  assign wr_data_o = wr_en_o ? data_q[head] : '0;
  assign count_o   = count;
  assign full_o    = full;
  assign empty_o   = empty;
  assign retired_o = retired;

  // Queue storage: written at tail, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= res_rd_i;
      data_q[tail] <= res_data_i;
    end
  end

  // Pointers, occupancy, retire counter and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      retired <= '0;
      state   <= RUN;
    end else begin
      state <= state_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head    <= head + 1'b1;
        retired <= retired + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state logic and the drain-complete pulse.
  always_comb begin
    state_nxt = state;
    drained_o = 1'b0;
    unique case (state)
      RUN:   if (drain_i) state_nxt = DRAIN;
      DRAIN: if (empty) begin
        state_nxt = RUN;
        drained_o = !reset;
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef WB_FORWARD_EN
  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    fwd_a_hit_o  = 1'b0;
    fwd_b_hit_o  = 1'b0;
    fwd_a_data_o = '0;
    fwd_b_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((rs1_i != '0) && (rd_q[idx] == rs1_i)) begin
          fwd_a_hit_o  = 1'b1;
          fwd_a_data_o = data_q[idx];
        end
        if ((rs2_i != '0) && (rd_q[idx] == rs2_i)) begin
          fwd_b_hit_o  = 1'b1;
          fwd_b_data_o = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{rs1_i, rs2_i};
  assign fwd_a_hit_o  = 1'b0;
  assign fwd_b_hit_o  = 1'b0;
  assign fwd_a_data_o = '0;
  assign fwd_b_data_o = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: scoreboard bench for writeback. Expected writes are queued as
// results are driven and compared as the DUT commits them.
module tb_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid_i, res_ready_o;
  logic [AW-1:0]     res_rd_i;
  logic [XLEN-1:0]   res_data_i;
  logic              wr_en_o;
  logic [AW-1:0]     wr_addr_o;
  logic [XLEN-1:0]   wr_data_o;
  logic              wr_ack_i, drain_i, drained_o;
  logic [$clog2(DEPTH):0] count_o;
  logic              full_o, empty_o;
  logic [31:0]       retired_o;
  logic [AW-1:0]     rs1_i, rs2_i;
  logic              fwd_a_hit_o, fwd_b_hit_o;
  logic [XLEN-1:0]   fwd_a_data_o, fwd_b_data_o;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+XLEN-1:0] sb[$];

  writeback #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_rd_i(res_rd_i), .res_data_i(res_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_ack_i(wr_ack_i), .drain_i(drain_i), .drained_o(drained_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .retired_o(retired_o), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .fwd_a_hit_o(fwd_a_hit_o), .fwd_b_hit_o(fwd_b_hit_o),
    .fwd_a_data_o(fwd_a_data_o), .fwd_b_data_o(fwd_b_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one result for a cycle; rd!=0 results are expected to commit later.
  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    res_valid_i = 1'b1;
    res_rd_i    = rd;
    res_data_i  = data;
    if (rd != '0) sb.push_back({rd, data});
    step();
    res_valid_i = 1'b0;
  endtask

  // Commit monitor: every write taken by the register file must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && wr_en_o && wr_ack_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, wr_addr_o, wr_data_o}, 64'd0);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(wr_addr_o), 64'(e[AW+XLEN-1:XLEN]));
        chk("wr_data", 64'(wr_data_o), 64'(e[XLEN-1:0]));
      end
    end
  end

  initial begin
    int pulses;
    int pulse_at;
    reset = 1'b1; res_valid_i = 1'b0; res_rd_i = '0; res_data_i = '0;
    wr_ack_i = 1'b0; drain_i = 1'b0; rs1_i = '0; rs2_i = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 64'(count_o), 0);
    chk("rst_empty", 64'(empty_o), 1);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_wr_en", 64'(wr_en_o), 0);
    chk("rst_wr_addr", 64'(wr_addr_o), 0);
    chk("rst_wr_data", 64'(wr_data_o), 0);
    chk("rst_retired", 64'(retired_o), 0);
    chk("rst_drained", 64'(drained_o), 0);
    chk("rst_ready", 64'(res_ready_o), 1);

    // Single result, one-cycle latency
    wr_ack_i = 1'b1;
    push(5'd3, 32'hDEADBEEF);
    chk("lat_wr_en", 64'(wr_en_o), 1);
    chk("lat_wr_addr", 64'(wr_addr_o), 3);
    chk("lat_wr_data", 64'(wr_data_o), 64'hDEADBEEF);
    step();
    chk("t1_retired", 64'(retired_o), 1);
    chk("t1_empty", 64'(empty_o), 1);

    // Fill to full with ack low, fifth offer refused
    wr_ack_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("fill_ready", 64'(res_ready_o), (i <= DEPTH) ? 1 : 0);
      res_valid_i = 1'b1;
      res_rd_i    = AW'(i);
      res_data_i  = 32'h100 + 32'(i);
      if (i <= DEPTH) sb.push_back({AW'(i), 32'h100 + 32'(i)});
      step();
    end
    res_valid_i = 1'b0;
    chk("full_flag", 64'(full_o), 1);
    chk("full_count", 64'(count_o), DEPTH);
    wr_ack_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("fill_empty", 64'(empty_o), 1);
    chk("fill_retired", 64'(retired_o), 5);

    // rd == 0 is consumed and dropped
    chk("x0_ready", 64'(res_ready_o), 1);
    push(5'd0, 32'h1234);
    chk("x0_wr_en", 64'(wr_en_o), 0);
    chk("x0_count", 64'(count_o), 0);
    step();
    chk("x0_retired", 64'(retired_o), 5);

    // Drain with three pending writes
    wr_ack_i = 1'b0;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    drain_i = 1'b1;
    step();
    drain_i = 1'b0;
    chk("drn_ready", 64'(res_ready_o), 0);
    chk("drn_count", 64'(count_o), 3);
    wr_ack_i = 1'b1;
    pulses = 0; pulse_at = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (drained_o) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("drn_pulses", 64'(pulses), 1);
    chk("drn_pulse_cycle", 64'(pulse_at), 3);
    chk("drn_ready_after", 64'(res_ready_o), 1);
    chk("drn_retired", 64'(retired_o), 8);

    // Drain with the queue already empty
    drain_i = 1'b1;
    step();
    drain_i = 1'b0;
    chk("drn0_pulse", 64'(drained_o), 1);
    chk("drn0_ready", 64'(res_ready_o), 0);
    step();
    chk("drn0_pulse_end", 64'(drained_o), 0);
    chk("drn0_ready_back", 64'(res_ready_o), 1);

    // Forwarding lookups
    wr_ack_i = 1'b0;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    push(5'd9, 32'h33);
    rs1_i = 5'd7; rs2_i = 5'd0;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_a_hit", 64'(fwd_a_hit_o), 1);
    chk("fwd_a_data", 64'(fwd_a_data_o), 64'h22);
    chk("fwd_b_hit_x0", 64'(fwd_b_hit_o), 0);
    rs2_i = 5'd9; #1;
    chk("fwd_b_hit", 64'(fwd_b_hit_o), 1);
    chk("fwd_b_data", 64'(fwd_b_data_o), 64'h33);
    rs1_i = 5'd8; #1;
    chk("fwd_a_miss", 64'(fwd_a_hit_o), 0);
`else
    chk("fwd_a_hit_off", 64'(fwd_a_hit_o), 0);
    chk("fwd_a_data_off", 64'(fwd_a_data_o), 0);
    rs2_i = 5'd9; #1;
    chk("fwd_b_hit_off", 64'(fwd_b_hit_o), 0);
    chk("fwd_b_data_off", 64'(fwd_b_data_o), 0);
`endif
    rs1_i = '0; rs2_i = '0;
    wr_ack_i = 1'b1;
    step(); step(); step();
    chk("fwd_drained", 64'(empty_o), 1);
    chk("fwd_retired", 64'(retired_o), 11);

    // Reset in the middle of draining discards pending writes
    wr_ack_i = 1'b0;
    push(5'd4, 32'h44);
    push(5'd5, 32'h55);
    wr_ack_i = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_wr_en", 64'(wr_en_o), 0);
    sb.delete();
    step();
    reset = 1'b0;
    chk("rst_mid_count", 64'(count_o), 0);
    chk("rst_mid_wr_en_after", 64'(wr_en_o), 0);
    chk("rst_mid_retired", 64'(retired_o), 0);
    step(); step(); step();
    chk("rst_mid_retired_hold", 64'(retired_o), 0);
    chk("sb_leftover", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Write-back stage for the Pillar core, the producer side of the register file that the decode stage reads.
- Accepts completed results (rd, data) from the execute/memory path and holds them in a small in-order queue.
- Drains one entry per cycle into the register-file write port.
- Supports a drain request that stops intake and reports when all pending writes have committed.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- XLEN, 32, data width.
- AW, 5, register address width; 32 architectural registers.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- res_valid_i  input  1  result offered
- res_ready_o  output  1  queue accepts a result this cycle
- res_rd_i  input  AW  destination register
- res_data_i  input  XLEN  result value
- wr_en_o  output  1  register-file write request (head entry valid)
- wr_addr_o  output  AW  head destination
- wr_data_o  output  XLEN  head value
- wr_ack_i  input  1  register file accepts the head this cycle
- drain_i  input  1  request to flush pending writes
- drained_o  output  1  one-cycle pulse when drain completes
- count_o  output  $clog2(DEPTH)+1  occupancy
- full_o  output  1  count_o == DEPTH
- empty_o  output  1  count_o == 0
- retired_o  output  32  committed-write counter
- rs1_i, rs2_i  input  AW  forwarding lookup addresses (WB_FORWARD_EN only)
- fwd_a_hit_o, fwd_b_hit_o  output  1  pending-write match (WB_FORWARD_EN only)
- fwd_a_data_o, fwd_b_data_o  output  XLEN  forwarded value (WB_FORWARD_EN only)

Behaviour:
- Reset is synchronous and active-high. On reset:
  - head/tail pointers, count_o and retired_o clear to 0.
  - State goes to RUN.
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0, drained_o=0, full_o=0, empty_o=1.
  - Reset mid-operation discards all queued writes; no write is issued in the reset cycle.
- Accept condition: res_valid_i && res_ready_o.
- res_ready_o = (state==RUN) && !full_o. It is derived from registered state only, with no combinational path from wr_ack_i.
- Accepted result with rd != 0 is enqueued at tail. Accepted result with rd == 0 is consumed and dropped: no enqueue, no retire count.
- wr_en_o = !empty_o. wr_addr_o and wr_data_o are driven from the head entry and are 0 when empty.
- Pop condition: wr_en_o && wr_ack_i. Pop advances head and increments retired_o, which wraps modulo 2^32.
- Latency: a result accepted in cycle N into an empty queue appears on wr_en_o in cycle N+1.
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Entries stay strictly in order.
- When full, res_ready_o=0. A pop in that cycle does not enable a same-cycle push.
- State machine, states RUN and DRAIN:
  - RUN -> DRAIN when drain_i=1 (sampled each cycle).
  - In DRAIN: res_ready_o=0 and the queue continues to pop.
  - DRAIN -> RUN in the first cycle the queue is empty after any pop. drained_o pulses high for exactly that one transition cycle.
  - drain_i with the queue already empty: enter DRAIN, then return to RUN with the drained_o pulse on the next cycle.
  - drain_i held high continuously re-enters DRAIN after each pulse.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - fwd_a_hit_o=1 when any valid queued entry has rd == rs1_i and rs1_i != 0.
  - fwd_a_data_o is the data of the youngest matching entry, otherwise 0. The B outputs behave the same for rs2_i.
  - All forwarding logic is purely combinational over registered queue contents. An entry popping in the current cycle still counts as a hit.
- Undefined: rs1_i/rs2_i are ignored, and hit/data outputs are tied to 0 while the ports remain present.

Test Plan:
- Reset, then push rd=3 data=0xDEADBEEF with wr_ack_i=1 -> wr_en_o=1, wr_addr_o=3, wr_data_o=0xDEADBEEF exactly 1 cycle later; retired_o=1; empty_o=1 afterwards.
- wr_ack_i=0, push rd=1..5 on consecutive cycles -> 4 entries accepted, full_o=1, res_ready_o=0 on the 5th; raising ack drains 1,2,3,4 in order over 4 cycles.
- Push rd=0 data=0x1234 -> accepted (ready high), no wr_en_o, count_o stays 0, retired_o unchanged.
- Hold 3 entries with ack=0, pulse drain_i -> res_ready_o=0 next cycle; ack=1 -> 3 writes, then drained_o high for exactly one cycle, state RUN, res_ready_o=1.
- WB_FORWARD_EN, ack=0, queue rd=7 0x11 then rd=7 0x22, rs1_i=7, rs2_i=0 -> fwd_a_hit_o=1, fwd_a_data_o=0x22, fwd_b_hit_o=0.
- Fill 2 entries, assert reset one cycle mid-drain -> next cycle count_o=0, wr_en_o=0, retired_o=0, no further writes.
